// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared constants and state encodings for the HD44780 character LCD driver.
//   - HD44780 command bytes used by the init and refresh sequences
//   - frame buffer geometry and sequence index limits
//   - top-level and byte-transfer state encodings
//   - init_cmd(): maps an init sequence index to its command byte
// ---------------------------------------------------------------------------
package lcd_pkg;

    // HD44780 command bytes
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (slow command)
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment address, no shift
    localparam logic [7:0] CMD_LINE0    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE1    = 8'hC0;  // DDRAM address 0x40

    localparam logic [7:0] CHAR_SPACE   = 8'h20;

    // Frame buffer: 2 rows x 16 columns, addressed as {row, col}
    localparam int unsigned FRAME_SIZE  = 32;

    // Last index of each byte sequence
    localparam logic [5:0] INIT_LAST    = 6'd3;   // 4 init commands
    localparam logic [5:0] REFRESH_LAST = 6'd33;  // 2 address cmds + 32 chars

    typedef enum logic [1:0] {
        S_PWR,
        S_INIT,
        S_IDLE,
        S_REFRESH
    } top_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_SETUP,
        B_EN,
        B_WAIT
    } byte_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_CLEAR;
            default: cmd = CMD_ENTRY;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// ---------------------------------------------------------------------------
// lcd_byte_tx
// Sends one byte to an HD44780 panel over the 8-bit parallel bus:
// setup (EN low), enable pulse (EN high), then an execution wait (EN low).
// The clear-display command gets the long wait, everything else the short one.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        load rs/data and begin a new byte (accepted in idle or on
//                the done cycle so bytes can run back to back)
//   rs, data     register select and byte to send
//   done         one-cycle pulse during the last wait cycle of the byte
//   lcd_data     panel data bus, held from start until the next start
//   lcd_rs       panel register select, held like lcd_data
//   lcd_en       panel enable strobe
// ---------------------------------------------------------------------------
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned EN_CYC    = 12,
    parameter int unsigned EXEC_CYC  = 2000,
    parameter int unsigned CLEAR_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en
);

    byte_state_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic        clear_q, clear_d;
    logic [31:0] wait_last;

    // The clear command is flagged when it is loaded so the wait length is
    // known without re-decoding the held byte every cycle.
    assign wait_last = clear_q ? (CLEAR_CYC - 1) : (EXEC_CYC - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = en_q;
        clear_d = clear_q;
        done    = 1'b0;

        case (state_q)
            B_SETUP: begin
                if (cnt_q == SETUP_CYC - 1) begin
                    state_d = B_EN;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            B_EN: begin
                if (cnt_q == EN_CYC - 1) begin
                    state_d = B_WAIT;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            B_WAIT: begin
                if (cnt_q == wait_last) begin
                    done    = 1'b1;
                    state_d = B_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
            end
        endcase

        // A start overrides the return to idle, giving gap-free byte streams.
        if (start) begin
            state_d = B_SETUP;
            cnt_d   = '0;
            data_d  = data;
            rs_d    = rs;
            en_d    = 1'b0;
            clear_d = (!rs) && (data == CMD_CLEAR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= B_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            clear_q <= clear_d;
        end
    end

    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_en   = en_q;

endmodule

// File: rtl/lcd_char_driver.sv
// ---------------------------------------------------------------------------
// lcd_char_driver
// Owns a 2x16 character frame buffer and the HD44780 panel pins. After reset
// it waits for panel power-up, sends the init commands, then copies the whole
// buffer to the panel each time a refresh is requested.
//
// Ports:
//   CLK, RST     clock and asynchronous active-low reset
//   lcd_row      buffer write row (0 = top)
//   lcd_col      buffer write column
//   lcd_char     character code to write
//   lcd_we       buffer write strobe, one character per cycle, any state
//   update       refresh request; requests while busy are remembered once
//   lcd_busy     high during power-up, init and refresh
//   LCD_DATA     panel data bus
//   LCD_RS       panel register select (0 = command, 1 = data)
//   LCD_RW       panel read/write, always write
//   LCD_EN       panel enable strobe
// ---------------------------------------------------------------------------
module lcd_char_driver
    import lcd_pkg::*;
#(
    parameter int unsigned POWERON_CYC = 750000,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned EN_CYC      = 12,
    parameter int unsigned EXEC_CYC    = 2000,
    parameter int unsigned CLEAR_CYC   = 82000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       lcd_row,
    input  logic [3:0] lcd_col,
    input  logic [7:0] lcd_char,
    input  logic       lcd_we,
    input  logic       update,
    output logic       lcd_busy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    top_state_t  state_q, state_d;
    logic [31:0] pwr_cnt_q, pwr_cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic        pending_q, pending_d;
    logic        busy_q, busy_d;
    logic        init_started_q, init_started_d;
    logic [7:0]  frame_q [FRAME_SIZE];
    logic [7:0]  frame_d [FRAME_SIZE];

    logic        tx_start;
    logic        tx_rs;
    logic [7:0]  tx_data;
    logic        tx_done;

    logic        seq_end;
    logic        launch_refresh;
    logic        seq_refresh;
    logic [5:0]  seq_idx;
    logic [4:0]  rd_addr;

    always_comb begin
        state_d        = state_q;
        pwr_cnt_d      = pwr_cnt_q;
        idx_d          = idx_q;
        pending_d      = pending_q;
        busy_d         = busy_q;
        init_started_d = init_started_q;
        frame_d        = frame_q;
        tx_start       = 1'b0;
        tx_rs          = 1'b0;
        tx_data        = '0;
        seq_end        = 1'b0;
        launch_refresh = 1'b0;
        seq_refresh    = 1'b0;
        seq_idx        = '0;
        rd_addr        = '0;

        if (lcd_we) begin
            frame_d[{lcd_row, lcd_col}] = lcd_char;
        end

        // Requests arriving while a sequence runs collapse into one flag.
        if ((state_q != S_IDLE) && update) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_PWR: begin
                if (pwr_cnt_q == POWERON_CYC - 1) begin
                    state_d        = S_INIT;
                    pwr_cnt_d      = '0;
                    idx_d          = '0;
                    init_started_d = 1'b0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 32'd1;
                end
            end
            S_INIT: begin
                if (!init_started_q) begin
                    init_started_d = 1'b1;
                    tx_start       = 1'b1;
                    seq_idx        = idx_q;
                end else if (tx_done) begin
                    if (idx_q == INIT_LAST) begin
                        seq_end = 1'b1;
                    end else begin
                        idx_d    = idx_q + 6'd1;
                        tx_start = 1'b1;
                        seq_idx  = idx_q + 6'd1;
                    end
                end
            end
            S_IDLE: begin
                if (update || pending_q) begin
                    launch_refresh = 1'b1;
                end
            end
            S_REFRESH: begin
                if (tx_done) begin
                    if (idx_q == REFRESH_LAST) begin
                        seq_end = 1'b1;
                    end else begin
                        idx_d       = idx_q + 6'd1;
                        tx_start    = 1'b1;
                        seq_refresh = 1'b1;
                        seq_idx     = idx_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = S_PWR;
            end
        endcase

        // At the end of a sequence a remembered request chains straight into
        // a refresh so busy never dips between the two.
        if (seq_end) begin
            if (pending_q || update) begin
                launch_refresh = 1'b1;
            end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        end

        if (launch_refresh) begin
            state_d     = S_REFRESH;
            idx_d       = '0;
            pending_d   = 1'b0;
            busy_d      = 1'b1;
            tx_start    = 1'b1;
            seq_refresh = 1'b1;
            seq_idx     = '0;
        end

        // Refresh order: line-0 address, 16 chars, line-1 address, 16 chars.
        // The 5-bit subtraction wraps so indices 18..33 land on 16..31.
        if (tx_start) begin
            if (!seq_refresh) begin
                tx_rs   = 1'b0;
                tx_data = init_cmd(seq_idx[1:0]);
            end else if (seq_idx == 6'd0) begin
                tx_rs   = 1'b0;
                tx_data = CMD_LINE0;
            end else if (seq_idx <= 6'd16) begin
                rd_addr = seq_idx[4:0] - 5'd1;
                tx_rs   = 1'b1;
                tx_data = frame_q[rd_addr];
            end else if (seq_idx == 6'd17) begin
                tx_rs   = 1'b0;
                tx_data = CMD_LINE1;
            end else begin
                rd_addr = seq_idx[4:0] - 5'd2;
                tx_rs   = 1'b1;
                tx_data = frame_q[rd_addr];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= S_PWR;
            pwr_cnt_q      <= '0;
            idx_q          <= '0;
            pending_q      <= 1'b0;
            busy_q         <= 1'b1;
            init_started_q <= 1'b0;
            for (int i = 0; i < FRAME_SIZE; i++) begin
                frame_q[i] <= CHAR_SPACE;
            end
        end else begin
            state_q        <= state_d;
            pwr_cnt_q      <= pwr_cnt_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            busy_q         <= busy_d;
            init_started_q <= init_started_d;
            frame_q        <= frame_d;
        end
    end

    lcd_byte_tx #(
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .EXEC_CYC  (EXEC_CYC),
        .CLEAR_CYC (CLEAR_CYC)
    ) u_byte_tx (
        .clk      (CLK),
        .rst_n    (RST),
        .start    (tx_start),
        .rs       (tx_rs),
        .data     (tx_data),
        .done     (tx_done),
        .lcd_data (LCD_DATA),
        .lcd_rs   (LCD_RS),
        .lcd_en   (LCD_EN)
    );

    assign lcd_busy = busy_q;
    assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_char_driver.sv
// ---------------------------------------------------------------------------
// tb_lcd_char_driver
// Drives lcd_char_driver with short timing parameters, captures every EN
// pulse on the panel bus and compares it against the byte stream the panel
// should see for the bench's own copy of the 2x16 character frame.
// ---------------------------------------------------------------------------
module tb_lcd_char_driver;

    localparam int P_PWR   = 20;
    localparam int P_SETUP = 2;
    localparam int P_EN    = 4;
    localparam int P_EXEC  = 10;
    localparam int P_CLEAR = 50;
    localparam int T_NORM  = P_SETUP + P_EN + P_EXEC;
    localparam int T_CLEAR = P_SETUP + P_EN + P_CLEAR;
    localparam int INIT_BUSY = 1 + P_PWR + 3 * T_NORM + T_CLEAR;
    localparam int REFRESH_BUSY = 34 * T_NORM;

    logic       CLK      = 1'b0;
    logic       RST      = 1'b1;
    logic       lcd_row  = 1'b0;
    logic [3:0] lcd_col  = '0;
    logic [7:0] lcd_char = '0;
    logic       lcd_we   = 1'b0;
    logic       update   = 1'b0;
    logic       lcd_busy;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    lcd_char_driver #(
        .POWERON_CYC (P_PWR),
        .SETUP_CYC   (P_SETUP),
        .EN_CYC      (P_EN),
        .EXEC_CYC    (P_EXEC),
        .CLEAR_CYC   (P_CLEAR)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .lcd_row  (lcd_row),
        .lcd_col  (lcd_col),
        .lcd_char (lcd_char),
        .lcd_we   (lcd_we),
        .update   (update),
        .lcd_busy (lcd_busy),
        .LCD_DATA (LCD_DATA),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_EN   (LCD_EN)
    );

    // Bench copy of what the panel should display
    logic [7:0] model [2][16];
    logic [8:0] exp_q [$];

    // One record per completed EN pulse: bus value at the rising edge, EN-low
    // cycles before it, EN-high cycles of the pulse.
    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         gap;
        int         len;
    } cap_t;
    cap_t cap_q [$];

    logic       en_prev = 1'b0;
    int         hi_cnt  = 0;
    int         lo_cnt  = 0;
    logic [7:0] cur_data = '0;
    logic       cur_rs   = 1'b0;
    int         cur_gap  = 0;

    // Panel-side monitor, sampled mid-cycle on the falling clock edge
    always @(negedge CLK) begin
        if (LCD_EN === 1'b1) begin
            if (!en_prev) begin
                cur_data = LCD_DATA;
                cur_rs   = LCD_RS;
                cur_gap  = lo_cnt;
                hi_cnt   = 1;
            end else begin
                hi_cnt++;
            end
        end else begin
            if (en_prev) begin
                cap_q.push_back('{cur_data, cur_rs, cur_gap, hi_cnt});
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
        end
        en_prev = (LCD_EN === 1'b1);
    end

    task automatic model_clear();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++)
                model[r][c] = 8'h20;
    endtask

    // The panel should see: line-0 address, top row, line-1 address, bottom row
    task automatic build_expected();
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h80});
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, model[0][c]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, model[1][c]});
    endtask

    // Counts pulses whose EN width or preceding low time is off; the low time
    // before a byte is the previous byte's wait plus this byte's setup.
    function automatic int timing_errors();
        int e = 0;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (cap_q[i].len != P_EN) e++;
            if (i > 0) begin
                int w;
                w = (cap_q[i-1].rs == 1'b0 && cap_q[i-1].data == 8'h01) ? P_CLEAR : P_EXEC;
                if (cap_q[i].gap != P_SETUP + w) e++;
            end
        end
        return e;
    endfunction

    task automatic count_busy(output int n);
        n = 0;
        while (lcd_busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic write_char(input logic r, input logic [3:0] c, input logic [7:0] ch);
        lcd_row  = r;
        lcd_col  = c;
        lcd_char = ch;
        lcd_we   = 1'b1;
        @(negedge CLK);
        lcd_we   = 1'b0;
        model[r][c] = ch;
    endtask

    task automatic run_refresh(output logic busy_next, output int n);
        cap_q.delete();
        update = 1'b1;
        @(negedge CLK);
        update = 1'b0;
        busy_next = lcd_busy;
        count_busy(n);
    endtask

    // Releases reset and checks power-up wait, init bytes and busy fall time
    task automatic test_init_sequence(input string tag);
        int k = 0;
        int en_early = 0;
        logic [8:0] init_exp [4];
        init_exp = '{9'h038, 9'h00C, 9'h001, 9'h006};
        @(negedge CLK);
        cap_q.delete();
        RST = 1'b1;
        while (k < 400) begin
            @(negedge CLK);
            k++;
            if (k <= P_PWR && LCD_EN !== 1'b0) en_early++;
            if (lcd_busy !== 1'b1) break;
        end
        checks++;
        if (k !== INIT_BUSY) $display("[TB] FAIL %s init_busy_len got %0d want %0d", tag, k, INIT_BUSY);
        else passed++;
        checks++;
        if (en_early !== 0) $display("[TB] FAIL %s poweron_en_quiet got %0d want 0", tag, en_early);
        else passed++;
        checks++;
        if (cap_q.size() !== 4) $display("[TB] FAIL %s init_count got %0d want 4", tag, cap_q.size());
        else passed++;
        for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
            checks++;
            if ({cap_q[i].rs, cap_q[i].data} !== init_exp[i])
                $display("[TB] FAIL %s init_byte%0d got %h want %h", tag, i, {cap_q[i].rs, cap_q[i].data}, init_exp[i]);
            else passed++;
        end
        checks++;
        if (timing_errors() !== 0) $display("[TB] FAIL %s init_timing got %0d want 0", tag, timing_errors());
        else passed++;
    endtask

    task automatic test_reset();
        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({lcd_busy, LCD_EN, LCD_RS, LCD_RW} !== 4'b1000)
            $display("[TB] FAIL reset_ctrl got %b want 1000", {lcd_busy, LCD_EN, LCD_RS, LCD_RW});
        else passed++;
        checks++;
        if (LCD_DATA !== 8'h00) $display("[TB] FAIL reset_data got %h want 00", LCD_DATA);
        else passed++;
        model_clear();
        test_init_sequence("reset");
    endtask

    task automatic test_idle_refresh();
        logic b;
        int n;
        run_refresh(b, n);
        build_expected();
        checks++;
        if (b !== 1'b1) $display("[TB] FAIL idle_busy_rise got %b want 1", b);
        else passed++;
        checks++;
        if (n !== REFRESH_BUSY) $display("[TB] FAIL idle_busy_len got %0d want %0d", n, REFRESH_BUSY);
        else passed++;
        checks++;
        if (cap_q.size() !== 34) $display("[TB] FAIL idle_count got %0d want 34", cap_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if ({cap_q[i].rs, cap_q[i].data} !== exp_q[i])
                $display("[TB] FAIL idle_byte%0d got %h want %h", i, {cap_q[i].rs, cap_q[i].data}, exp_q[i]);
            else passed++;
        end
        checks++;
        if (timing_errors() !== 0) $display("[TB] FAIL idle_timing got %0d want 0", timing_errors());
        else passed++;
        checks++;
        if (LCD_RW !== 1'b0) $display("[TB] FAIL rw_tied got %b want 0", LCD_RW);
        else passed++;
    endtask

    task automatic test_hello_world();
        logic b;
        int n;
        logic [39:0] got0;
        logic [55:0] got1;
        logic [39:0] hello;
        logic [55:0] world;
        hello = "HELLO";
        world = "  WORLD";
        for (int i = 0; i < 5; i++) write_char(1'b0, 4'(i), hello[8*(4-i) +: 8]);
        for (int i = 0; i < 5; i++) write_char(1'b1, 4'(i + 2), world[8*(4-i) +: 8]);
        run_refresh(b, n);
        build_expected();
        got0 = 'x;
        got1 = 'x;
        if (cap_q.size() == 34) begin
            for (int i = 0; i < 5; i++) got0[8*(4-i) +: 8] = cap_q[1 + i].data;
            for (int i = 0; i < 7; i++) got1[8*(6-i) +: 8] = cap_q[18 + i].data;
        end
        checks++;
        if (got0 !== hello) $display("[TB] FAIL hello_line0 got %h want %h", got0, hello);
        else passed++;
        checks++;
        if (got1 !== world) $display("[TB] FAIL world_line1 got %h want %h", got1, world);
        else passed++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if ({cap_q[i].rs, cap_q[i].data} !== exp_q[i])
                $display("[TB] FAIL hello_byte%0d got %h want %h", i, {cap_q[i].rs, cap_q[i].data}, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_random_frame();
        logic b;
        int n;
        for (int it = 0; it < 2; it++) begin
            for (int w = 0; w < 12; w++)
                write_char(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(33, 126)));
            run_refresh(b, n);
            build_expected();
            checks++;
            if (cap_q.size() !== 34) $display("[TB] FAIL rand%0d_count got %0d want 34", it, cap_q.size());
            else passed++;
            for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
                checks++;
                if ({cap_q[i].rs, cap_q[i].data} !== exp_q[i])
                    $display("[TB] FAIL rand%0d_byte%0d got %h want %h", it, i, {cap_q[i].rs, cap_q[i].data}, exp_q[i]);
                else passed++;
            end
        end
    endtask

    // Three requests during a refresh must yield exactly one more refresh
    task automatic test_back_to_back();
        int t0, t1, t2, n;
        logic b;
        t0 = $urandom_range(5, 100);
        t1 = t0 + $urandom_range(2, 100);
        t2 = t1 + $urandom_range(2, 100);
        cap_q.delete();
        update = 1'b1;
        @(negedge CLK);
        update = 1'b0;
        b = lcd_busy;
        n = 0;
        while (lcd_busy === 1'b1 && n < 5000) begin
            n++;
            update = (n == t0 || n == t1 || n == t2);
            @(negedge CLK);
        end
        update = 1'b0;
        build_expected();
        for (int i = 0; i < 34; i++) exp_q.push_back(exp_q[i]);
        checks++;
        if (b !== 1'b1) $display("[TB] FAIL b2b_busy_rise got %b want 1", b);
        else passed++;
        checks++;
        if (n !== 2 * REFRESH_BUSY) $display("[TB] FAIL b2b_busy_len got %0d want %0d", n, 2 * REFRESH_BUSY);
        else passed++;
        repeat (60) @(negedge CLK);
        checks++;
        if (lcd_busy !== 1'b0) $display("[TB] FAIL b2b_no_third got %b want 0", lcd_busy);
        else passed++;
        checks++;
        if (cap_q.size() !== 68) $display("[TB] FAIL b2b_count got %0d want 68", cap_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if ({cap_q[i].rs, cap_q[i].data} !== exp_q[i])
                $display("[TB] FAIL b2b_byte%0d got %h want %h", i, {cap_q[i].rs, cap_q[i].data}, exp_q[i]);
            else passed++;
        end
        checks++;
        if (timing_errors() !== 0) $display("[TB] FAIL b2b_timing got %0d want 0", timing_errors());
        else passed++;
    endtask

    // A byte samples the frame when its setup starts: a write one cycle
    // earlier is seen, a write in that same cycle is not.
    task automatic test_sample_boundary();
        logic       r;
        logic [3:0] c;
        logic [7:0] ch;
        logic [8:0] got;
        logic [8:0] want;
        int idx, k, n;
        for (int it = 0; it < 2; it++) begin
            if (it == 0) begin
                r = 1'b1; c = 4'd15; ch = 8'h5A;
            end else begin
                r = 1'($urandom_range(0, 1));
                c = 4'($urandom_range(0, 15));
                ch = 8'($urandom_range(33, 126));
            end
            idx = r ? 18 + int'(c) : 1 + int'(c);
            k = idx * T_NORM;
            for (int mode = 0; mode < 2; mode++) begin
                write_char(r, c, 8'h20);
                cap_q.delete();
                update = 1'b1;
                @(negedge CLK);
                update = 1'b0;
                repeat (k - 2 + mode) @(negedge CLK);
                write_char(r, c, ch);
                count_busy(n);
                got = (cap_q.size() > idx) ? {cap_q[idx].rs, cap_q[idx].data} : 9'bx;
                want = {1'b1, (mode == 0) ? ch : 8'h20};
                checks++;
                if (got !== want)
                    $display("[TB] FAIL sample%0d_mode%0d_byte%0d got %h want %h", it, mode, idx, got, want);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_refresh();
        int w = 0;
        logic b;
        int n;
        logic en_before;
        cap_q.delete();
        update = 1'b1;
        @(negedge CLK);
        update = 1'b0;
        repeat ($urandom_range(50, 400)) @(negedge CLK);
        while (LCD_EN !== 1'b1 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        en_before = LCD_EN;
        #2 RST = 1'b0;
        #1;
        checks++;
        if (en_before !== 1'b1) $display("[TB] FAIL mid_en_seen got %b want 1", en_before);
        else passed++;
        checks++;
        if ({lcd_busy, LCD_EN} !== 2'b10) $display("[TB] FAIL mid_async_reset got %b want 10", {lcd_busy, LCD_EN});
        else passed++;
        repeat (3) @(negedge CLK);
        model_clear();
        test_init_sequence("mid_reset");
        run_refresh(b, n);
        build_expected();
        checks++;
        if (n !== REFRESH_BUSY) $display("[TB] FAIL mid_refresh_len got %0d want %0d", n, REFRESH_BUSY);
        else passed++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if ({cap_q[i].rs, cap_q[i].data} !== exp_q[i])
                $display("[TB] FAIL mid_byte%0d got %h want %h", i, {cap_q[i].rs, cap_q[i].data}, exp_q[i]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_idle_refresh();
        test_hello_world();
        test_random_frame();
        test_back_to_back();
        test_sample_boundary();
        test_reset_mid_refresh();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
